// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if: issue, operand, forwarding and retire signals between EX and the scoreboard
interface fwd_scoreboard_if #(
  parameter int FULLW = 32,
  parameter int REGAW = 4,
  parameter int NREAD = 3
);
  logic                   issue_valid;
  logic                   issue_we;
  logic [REGAW-1:0]       issue_wa;
  logic                   issue_is_load;
  logic [FULLW-1:0]       ex_result;
  logic [FULLW-1:0]       mem_result;
  logic [NREAD*REGAW-1:0] src_a;
  logic [NREAD-1:0]       src_used;
  logic [NREAD*FULLW-1:0] rf_data;
  logic                   flush;
  logic [NREAD*FULLW-1:0] fwd_data;
  logic                   stall;
  logic                   wb_valid;
  logic [REGAW-1:0]       wb_wa;
  logic [FULLW-1:0]       wb_wd;
  logic [15:0]            stall_cnt;
  modport master (
    output issue_valid, issue_we, issue_wa, issue_is_load, ex_result, mem_result,
           src_a, src_used, rf_data, flush,
    input  fwd_data, stall, wb_valid, wb_wa, wb_wd, stall_cnt
  );
  modport slave (
    input  issue_valid, issue_we, issue_wa, issue_is_load, ex_result, mem_result,
           src_a, src_used, rf_data, flush,
    output fwd_data, stall, wb_valid, wb_wa, wb_wd, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: in-flight write tracking, operand forwarding, load-use stall and retire port
module fwd_scoreboard #(
  parameter int FULLW       = 32,
  parameter int REGAW       = 4,
  parameter int DEPTH       = 3,
  parameter int NREAD       = 3,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_SLOTS = 1,
  parameter int PC_IDX      = 15
) (
  input logic            clk,
  input logic            reset,
  fwd_scoreboard_if.slave bus
);
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] pending;
  logic [REGAW-1:0] wa [DEPTH];
  logic [FULLW-1:0] data [DEPTH];
  logic [NREAD-1:0] hazard;
  logic [15:0]      cnt;

  for (genvar i = 0; i < NREAD; i++) begin : g_port
    logic [REGAW-1:0] src;
    logic [FULLW-1:0] rf;
    logic [FULLW-1:0] fwd;
    logic             hit_pend;
    assign src = bus.src_a[i*REGAW +: REGAW];
    assign rf  = bus.rf_data[i*FULLW +: FULLW];
    // scan oldest to youngest so the youngest matching slot has the last word
    always_comb begin
      fwd      = rf;
      hit_pend = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--)
        if (valid[k] && wa[k] == src && bus.src_used[i] && src != REGAW'(PC_IDX)) begin
          fwd      = pending[k] ? rf : data[k];
          hit_pend = pending[k];
        end
    end
    assign bus.fwd_data[i*FULLW +: FULLW] = fwd;
    assign hazard[i] = hit_pend;
  end

  assign bus.stall     = ~bus.flush & bus.issue_valid & |hazard;
  assign bus.wb_valid  = valid[DEPTH-1] & ~pending[DEPTH-1];
  assign bus.wb_wa     = wa[DEPTH-1];
  assign bus.wb_wd     = data[DEPTH-1];
  assign bus.stall_cnt = cnt;

  // flush kills the issue plus the FLUSH_SLOTS youngest pre-edge slots (post-shift 1..FLUSH_SLOTS)
  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= '0;
      pending <= '0;
      cnt     <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        wa[k]   <= '0;
        data[k] <= '0;
      end
    end else begin
      valid[0]   <= bus.issue_valid & bus.issue_we & ~bus.stall & ~bus.flush;
      wa[0]      <= bus.issue_wa;
      pending[0] <= bus.issue_is_load;
      data[0]    <= bus.ex_result;
      for (int k = 1; k < DEPTH; k++) begin
        valid[k]   <= valid[k-1] & ~(bus.flush & (k <= FLUSH_SLOTS));
        wa[k]      <= wa[k-1];
        pending[k] <= pending[k-1] & (k != LOAD_LAT);
        data[k]    <= (k == LOAD_LAT && pending[k-1]) ? bus.mem_result : data[k-1];
      end
      cnt <= cnt + 16'(bus.stall && cnt != 16'hFFFF);
    end
  end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: random issue streams into two scoreboard configurations vs an age-based model
module tb_fwd_scoreboard;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  typedef struct {
    int          wa;
    bit          ld;
    logic [31:0] d;
    int          t;
  } rec_t;

  int cd [2] = '{3, 4};
  int cl [2] = '{1, 2};
  int cf [2] = '{1, 2};

  rec_t        q [2][$];
  logic [31:0] rf [2][16];
  logic [95:0] rfd [2];
  int          scnt [2];
  bit          est [2];
  int          cyc;
  int          n_chk;
  int          n_err;

  logic        iv, we, ld, fl;
  logic [3:0]  wa;
  logic [31:0] ex, mem;
  logic [3:0]  src [3];
  logic [2:0]  used;

  fwd_scoreboard_if #(.FULLW(32), .REGAW(4), .NREAD(3)) b0 ();
  fwd_scoreboard_if #(.FULLW(32), .REGAW(4), .NREAD(3)) b1 ();

  assign b0.issue_valid = iv;   assign b1.issue_valid = iv;
  assign b0.issue_we = we;      assign b1.issue_we = we;
  assign b0.issue_wa = wa;      assign b1.issue_wa = wa;
  assign b0.issue_is_load = ld; assign b1.issue_is_load = ld;
  assign b0.ex_result = ex;     assign b1.ex_result = ex;
  assign b0.mem_result = mem;   assign b1.mem_result = mem;
  assign b0.flush = fl;         assign b1.flush = fl;
  assign b0.src_a = {src[2], src[1], src[0]};
  assign b1.src_a = {src[2], src[1], src[0]};
  assign b0.src_used = used;    assign b1.src_used = used;
  assign b0.rf_data = rfd[0];   assign b1.rf_data = rfd[1];

  fwd_scoreboard u0 (.clk(clk), .reset(reset), .bus(b0));
  fwd_scoreboard #(.DEPTH(4), .LOAD_LAT(2), .FLUSH_SLOTS(2)) u1 (.clk(clk), .reset(reset), .bus(b1));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] rreg();
    int r = $urandom_range(0, 7);
    return (r == 7) ? 4'd15 : 4'(r);
  endfunction

  // youngest in-flight write to s; a load is unresolved until its age exceeds LOAD_LAT
  task automatic look(int c, logic [3:0] s, output bit hit, output bit pend, output logic [31:0] val);
    hit = 0; pend = 0; val = '0;
    foreach (q[c][j]) begin
      int age = cyc - q[c][j].t;
      if (!hit && age >= 1 && age <= cd[c] && q[c][j].wa == int'(s)) begin
        hit  = 1;
        pend = q[c][j].ld && age <= cl[c];
        val  = q[c][j].d;
      end
    end
  endtask

  task automatic check(int c, int n, logic [95:0] fd, logic st, logic wv, logic [3:0] ww,
                       logic [31:0] wd, logic [15:0] sc);
    bit any = 0, hit, pend, wexp = 0;
    logic [31:0] val, ew = '0;
    int eaddr = 0;
    for (int i = 0; i < 3; i++)
      if (used[i] && src[i] != 4'd15) begin
        look(c, src[i], hit, pend, val);
        if (hit && pend) any = 1;
      end
    est[c] = !fl && iv && any;
    chk($sformatf("c%0d stall", c), 32'(st), 32'(est[c]));
    for (int i = 0; i < 3; i++) begin
      hit = 0; pend = 0; val = '0;
      if (used[i] && src[i] != 4'd15) look(c, src[i], hit, pend, val);
      if (!(hit && pend))
        chk($sformatf("c%0d fwd%0d", c, i), fd[i*32 +: 32], hit ? val : rfd[c][i*32 +: 32]);
    end
    foreach (q[c][j])
      if (cyc - q[c][j].t == cd[c]) begin
        wexp = 1; eaddr = q[c][j].wa; ew = q[c][j].d;
      end
    chk($sformatf("c%0d wb_valid", c), 32'(wv), 32'(wexp));
    if (wexp) begin
      chk($sformatf("c%0d wb_wa", c), 32'(ww), 32'(eaddr));
      chk($sformatf("c%0d wb_wd", c), wd, ew);
    end
    if (n == 2 || n == 1501) begin
      chk($sformatf("c%0d rst_wb_wa", c), 32'(ww), 32'd0);
      chk($sformatf("c%0d rst_wb_wd", c), wd, 32'd0);
    end
    chk($sformatf("c%0d stall_cnt", c), 32'(sc), 32'(scnt[c]));
  endtask

  task automatic step(int c);
    rec_t nq [$];
    if (reset) begin
      q[c].delete();
      scnt[c] = 0;
      return;
    end
    foreach (q[c][j]) begin
      int age = cyc - q[c][j].t;
      if (age == cd[c]) rf[c][q[c][j].wa] = q[c][j].d;
      if (q[c][j].ld && age == cl[c]) q[c][j].d = mem;
      if (age < cd[c] && !(fl && age <= cf[c])) nq.push_back(q[c][j]);
    end
    q[c] = nq;
    if (est[c] && scnt[c] < 65535) scnt[c]++;
    if (iv && we && !est[c] && !fl) q[c].push_front('{wa: int'(wa), ld: ld, d: ex, t: cyc});
  endtask

  task automatic drive(int n);
    reset = (n < 2 || n == 1500);
    iv   = ($urandom_range(0, 9) < 8);
    we   = ($urandom_range(0, 9) < 8);
    ld   = ($urandom_range(0, 9) < 3);
    fl   = ($urandom_range(0, 99) < 8);
    wa   = rreg();
    ex   = $urandom;
    mem  = $urandom;
    used = 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7));
    for (int i = 0; i < 3; i++) src[i] = rreg();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 3; i++) rfd[c][i*32 +: 32] = rf[c][src[i]];
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    for (int c = 0; c < 2; c++) begin
      scnt[c] = 0;
      for (int r = 0; r < 16; r++) rf[c][r] = $urandom;
    end
    drive(0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 3000; n++) begin
      drive(n);
      @(negedge clk);
      check(0, n, b0.fwd_data, b0.stall, b0.wb_valid, b0.wb_wa, b0.wb_wd, b0.stall_cnt);
      check(1, n, b1.fwd_data, b1.stall, b1.wb_valid, b1.wb_wa, b1.wb_wd, b1.stall_cnt);
      @(posedge clk);
      step(0);
      step(1);
      cyc++;
      #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
